// File: rtl/pipeline_pkg.sv
// Shared pipeline widths and bundles.
// Used by the writeback arbiter and its scoreboard.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  typedef struct packed {
    reg_addr_t rd;
    reg_data_t data;
  } rf_wr_t;

  function automatic logic is_r0(input reg_addr_t a);
    return a == '0;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Signals between WB, mul/div, decode and the
// register-file write port arbiter.
interface rf_wb_arbiter_if;
  import pipeline_pkg::*;

  logic      wb_valid;
  reg_addr_t wb_rd;
  reg_data_t wb_data;
  logic      md_issue;
  reg_addr_t md_issue_rd;
  logic      md_valid;
  reg_addr_t md_rd;
  reg_data_t md_data;
  logic      md_ready;
  reg_addr_t PR1;
  reg_addr_t PR2;
  logic      busy1;
  logic      busy2;
  logic      stall_wb;
  logic      write;
  reg_addr_t WR;
  reg_data_t WD;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output md_issue, md_issue_rd,
    output md_valid, md_rd, md_data,
    output PR1, PR2,
    input  md_ready, busy1, busy2,
    input  stall_wb, write, WR, WD
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  md_issue, md_issue_rd,
    input  md_valid, md_rd, md_data,
    input  PR1, PR2,
    output md_ready, busy1, busy2,
    output stall_wb, write, WR, WD
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write bits for mul/div destinations.
// Set beats clear on the same bit; r0 is never pending.
module rf_scoreboard
  import pipeline_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en,
  input  reg_addr_t set_idx,
  input  logic      clr_en,
  input  reg_addr_t clr_idx,
  input  reg_addr_t rd_idx1,
  input  reg_addr_t rd_idx2,
  output logic      busy1,
  output logic      busy2
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_nxt;

  // Apply clear first so a same-cycle set wins.
  always_comb begin
    pend_nxt = pend_q;
    if (clr_en)
      pend_nxt[clr_idx] = 1'b0;
    if (set_en)
      pend_nxt[set_idx] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Pending vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pend_q <= '0;
    else
      pend_q <= pend_nxt;
  end

  assign busy1 = pend_q[rd_idx1];
  assign busy2 = pend_q[rd_idx2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port shared by WB and mul/div.
// WB has priority; a starved buffered result forces a WB stall.
module rf_wb_arbiter
  import pipeline_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  rf_wb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic             buf_full;
  rf_wr_t           buf_q;
  logic [CNT_W-1:0] starve_cnt;

  logic   stall;
  logic   buf_grant;
  logic   wb_grant;
  logic   md_acc;
  rf_wr_t sel;

  assign stall =
    buf_full && (starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign buf_grant =
    reset && (stall || (buf_full && !bus.wb_valid));
  assign wb_grant =
    reset && !stall && bus.wb_valid;
  assign md_acc = bus.md_valid && !buf_full;

  // Pick the write source for this cycle.
  always_comb begin
    sel = '0;
    if (buf_grant)
      sel = buf_q;
    else if (wb_grant)
      sel = '{rd: bus.wb_rd, data: bus.wb_data};
  end

  assign bus.write    = (buf_grant || wb_grant) &&
                        !is_r0(sel.rd);
  assign bus.WR       = sel.rd;
  assign bus.WD       = sel.data;
  assign bus.stall_wb = stall;
  assign bus.md_ready = !buf_full;

  // One-entry result buffer and starvation counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full   <= 1'b0;
      buf_q      <= '0;
      starve_cnt <= '0;
    end else begin
      if (buf_grant) begin
        buf_full   <= 1'b0;
        starve_cnt <= '0;
      end else if (buf_full && ~&starve_cnt) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (md_acc) begin
        buf_full   <= 1'b1;
        buf_q      <= '{rd: bus.md_rd, data: bus.md_data};
        starve_cnt <= '0;
      end
    end
  end

  rf_scoreboard u_sb (
    .clk     (clk),
    .rst_n   (reset),
    .set_en  (bus.md_issue && !is_r0(bus.md_issue_rd)),
    .set_idx (bus.md_issue_rd),
    .clr_en  (buf_grant),
    .clr_idx (buf_q.rd),
    .rd_idx1 (bus.PR1),
    .rd_idx2 (bus.PR2),
    .busy1   (bus.busy1),
    .busy2   (bus.busy2)
  );

endmodule
